// File: rtl/cond_issue_queue_pkg.sv
// Shared widths, entry/wakeup record types and the condition-update helper
// used by the condition-wait issue queue.
package cq_pkg;

  localparam int DATA_WIDTH      = 248;
  localparam int CONDITION_WIDTH = 2;
  localparam int INDEX_WIDTH     = 4;

  typedef struct packed {
    logic                       valid;
    logic [DATA_WIDTH-1:0]      data;
    logic [CONDITION_WIDTH-1:0] cond;
    logic [INDEX_WIDTH-1:0]     index;
  } entry_t;

  typedef struct packed {
    logic                       valid;
    logic [INDEX_WIDTH-1:0]     index;
    logic [CONDITION_WIDTH-1:0] mask;
    logic [CONDITION_WIDTH-1:0] value;
  } wk_chan_t;

  // Overwrite the masked condition bits with the merged wakeup value.
  function automatic logic [CONDITION_WIDTH-1:0] apply_wake(
    input logic [CONDITION_WIDTH-1:0] cond,
    input logic [CONDITION_WIDTH-1:0] mask,
    input logic [CONDITION_WIDTH-1:0] value
  );
    return (value & mask) | (cond & ~mask);
  endfunction

endpackage

// File: rtl/cond_issue_queue_if.sv
// Enqueue / wakeup / dequeue bundle of the condition-wait issue queue.
// master = producer/consumer side, slave = the queue itself.
interface cond_issue_queue_if import cq_pkg::*; #(
  parameter int DEPTH    = 8,
  parameter int WK_PORTS = 2
);
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

  logic                                      flush;
  logic                                      enq_valid;
  logic                                      enq_ready;
  logic [DATA_WIDTH-1:0]                     enq_data;
  logic [CONDITION_WIDTH-1:0]                enq_condition;
  logic [INDEX_WIDTH-1:0]                    enq_index;
  logic [WK_PORTS-1:0]                       wk_valid;
  logic [WK_PORTS-1:0][INDEX_WIDTH-1:0]      wk_index;
  logic [WK_PORTS-1:0][CONDITION_WIDTH-1:0]  wk_mask;
  logic [WK_PORTS-1:0][CONDITION_WIDTH-1:0]  wk_value;
  logic                                      deq_valid;
  logic                                      deq_ready;
  logic [DATA_WIDTH-1:0]                     deq_data;
  logic [INDEX_WIDTH-1:0]                    deq_index;
  logic [COUNT_WIDTH-1:0]                    count;
  logic                                      empty;
  logic                                      full;

  modport master (
    output flush, enq_valid, enq_data, enq_condition, enq_index,
           wk_valid, wk_index, wk_mask, wk_value, deq_ready,
    input  enq_ready, deq_valid, deq_data, deq_index, count, empty, full
  );

  modport slave (
    input  flush, enq_valid, enq_data, enq_condition, enq_index,
           wk_valid, wk_index, wk_mask, wk_value, deq_ready,
    output enq_ready, deq_valid, deq_data, deq_index, count, empty, full
  );

endinterface

// File: rtl/cond_issue_queue_slot.sv
// One queue entry: flush > dequeue > enqueue write > wakeup, plus a ready flag
// (valid with every condition bit set).
module cq_slot import cq_pkg::*; (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       deq,
  input  logic                       wr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [CONDITION_WIDTH-1:0] wr_cond,
  input  logic [INDEX_WIDTH-1:0]     wr_index,
  input  logic [CONDITION_WIDTH-1:0] wk_mask,
  input  logic [CONDITION_WIDTH-1:0] wk_value,
  output entry_t                     entry,
  output logic                       ready
);

  // Entry register; a dequeued entry ignores any wakeup aimed at it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry <= '0;
    end else if (flush || deq) begin
      entry <= '0;
    end else if (wr) begin
      entry <= '{valid: 1'b1, data: wr_data, cond: wr_cond, index: wr_index};
    end else if (entry.valid) begin
      entry.cond <= apply_wake(entry.cond, wk_mask, wk_value);
    end
  end

  assign ready = entry.valid && (&entry.cond);

endmodule

// File: rtl/cond_issue_queue.sv
// Condition-wait issue queue: free-slot allocation, age matrix, oldest-ready
// selection, multi-channel wakeup merge and occupancy count.
module cond_issue_queue import cq_pkg::*; #(
  parameter int DEPTH    = 8,
  parameter int WK_PORTS = 2
) (
  input logic clock,
  input logic reset,
  cond_issue_queue_if.slave q
);

  localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

  entry_t                                entry [DEPTH];
  wk_chan_t                              wk [WK_PORTS];
  logic [DEPTH-1:0]                      valid;
  logic [DEPTH-1:0]                      ready;
  logic [DEPTH-1:0]                      wr_vec;
  logic [DEPTH-1:0]                      sel;
  logic [DEPTH-1:0]                      deq_vec;
  logic [DEPTH-1:0][CONDITION_WIDTH-1:0] slot_m;
  logic [DEPTH-1:0][CONDITION_WIDTH-1:0] slot_v;
  logic [CONDITION_WIDTH-1:0]            enq_m;
  logic [CONDITION_WIDTH-1:0]            enq_v;
  logic [CONDITION_WIDTH-1:0]            enq_cond;
  // older[i][j] = 1 when entry i was enqueued before entry j
  logic [DEPTH-1:0][DEPTH-1:0]           older;
  logic [COUNT_WIDTH-1:0]                count_r;
  logic                                  has_free;
  logic                                  enq_ready;
  logic                                  enq_fire;
  logic                                  deq_valid;
  logic                                  deq_fire;
  logic [DATA_WIDTH-1:0]                 deq_data;
  logic [INDEX_WIDTH-1:0]                deq_index;

  // Repack the flat wakeup ports into channel records.
  always_comb begin
    for (int c = 0; c < WK_PORTS; c++) begin
      wk[c].valid = q.wk_valid[c];
      wk[c].index = q.wk_index[c];
      wk[c].mask  = q.wk_mask[c];
      wk[c].value = q.wk_value[c];
    end
  end

  // Merge matching wakeup channels per entry and for the incoming enqueue.
  always_comb begin
    enq_m  = '0;
    enq_v  = '0;
    slot_m = '0;
    slot_v = '0;
    for (int c = 0; c < WK_PORTS; c++) begin
      if (wk[c].valid) begin
        if (wk[c].index == q.enq_index) begin
          enq_m = enq_m | wk[c].mask;
          enq_v = enq_v | (wk[c].value & wk[c].mask);
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (valid[i] && (entry[i].index == wk[c].index)) begin
            slot_m[i] = slot_m[i] | wk[c].mask;
            slot_v[i] = slot_v[i] | (wk[c].value & wk[c].mask);
          end
        end
      end
    end
  end

  assign enq_cond  = apply_wake(q.enq_condition, enq_m, enq_v);
  assign has_free  = ~&valid;
  assign enq_ready = has_free && !q.flush;
  assign enq_fire  = q.enq_valid && enq_ready;

  // Lowest-numbered free slot receives the enqueue.
  always_comb begin
    logic found;
    found  = 1'b0;
    wr_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid[i] && !found) begin
        wr_vec[i] = enq_fire;
        found     = 1'b1;
      end
    end
  end

  // Oldest ready entry: ready and no other ready entry is older than it.
  always_comb begin
    logic blocked;
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && older[j][i]) blocked = 1'b1;
      end
      sel[i] = ready[i] && !blocked;
    end
  end

  // Payload mux; sel is one-hot or zero so an OR-reduction suffices.
  always_comb begin
    deq_data  = '0;
    deq_index = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        deq_data  = deq_data | entry[i].data;
        deq_index = deq_index | entry[i].index;
      end
    end
  end

  assign deq_valid = (|sel) && !q.flush;
  assign deq_fire  = deq_valid && q.deq_ready;
  assign deq_vec   = sel & {DEPTH{deq_fire}};

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    cq_slot u_slot (
      .clock    (clock),
      .reset    (reset),
      .flush    (q.flush),
      .deq      (deq_vec[g]),
      .wr       (wr_vec[g]),
      .wr_data  (q.enq_data),
      .wr_cond  (enq_cond),
      .wr_index (q.enq_index),
      .wk_mask  (slot_m[g]),
      .wk_value (slot_v[g]),
      .entry    (entry[g]),
      .ready    (ready[g])
    );
    assign valid[g] = entry[g].valid;
  end

  // Age matrix: a new entry is younger than every live one; a dequeued
  // entry drops out of both its row and column.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      older <= '0;
    end else if (q.flush) begin
      older <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (deq_vec[i] || deq_vec[j] || wr_vec[i]) begin
            older[i][j] <= 1'b0;
          end else if (wr_vec[j]) begin
            older[i][j] <= valid[i];
          end
        end
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (q.flush) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + COUNT_WIDTH'(enq_fire) - COUNT_WIDTH'(deq_fire);
    end
  end

  assign q.enq_ready = enq_ready;
  assign q.deq_valid = deq_valid;
  assign q.deq_data  = deq_data;
  assign q.deq_index = deq_index;
  assign q.count     = count_r;
  assign q.empty     = (count_r == '0);
  assign q.full      = (count_r == COUNT_WIDTH'(DEPTH));

endmodule
